hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Forwarding and hazard controller for the 5-stage pipelined MIPS core; drives the 2-bit select inputs of the two EX-stage ALU-operand 4:1 muxes (A and B). Tracks the destination register of each in-flight instruction (EX, MEM, WB) internally. Computes forwarding selects while the consumer is in ID and registers them into EX. Detects load-use hazards, stalls IF/ID for one cycle with a bubble, and squashes tracked state on a taken branch.

## Interface
Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, width of load-use stall statistics counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ext_stall  in  1  global pipeline freeze (memory wait); all internal state holds
- br_taken  in  1  branch resolved taken in EX this cycle
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_dest  in  REG_AW  ID destination register (rd or rt, already muxed)
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- fwd_a_sel, fwd_b_sel  out  2  registered operand-mux selects for the instruction in EX
- stall  out  1  hold PC and IF/ID (combinational)
- bubble_id_ex  out  1  zero ID/EX control this edge (combinational)
- flush_if_id  out  1  squash IF/ID (combinational, = br_taken)
- lu_stall_cnt  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Select encoding: 00 = register-file value, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value. 11 is never driven: the operand mux has no 11 arm and would latch.
- Tracking: three stage records {valid, dest, reg_write, mem_read}, one each for EX, MEM, and WB. They advance every non-frozen cycle. The EX record loads from id_* unless bubbled or flushed; otherwise it loads valid=0.
- Match(src) = uses && src != 0 && record.valid && record.reg_write && record.dest == src.
- Select per operand, evaluated in ID: match on EX record -> 01; else match on MEM record -> 10; else 00. Nearest producer wins. A WB-record match gives 00, because the register file writes in the first half-cycle.
- Load-use: id_valid && EX.mem_read && (Match(id_rs) || Match(id_rt)). Response: stall=1, bubble_id_ex=1, EX record loads a bubble, registered selects load 00.
- Next cycle the load sits in MEM and the consumer is re-evaluated, giving select 10. A stall never exceeds one cycle per load.
- br_taken: flush_if_id=1, bubble_id_ex=1, stall=0. The EX record loads a bubble and the selects load 00.
- Priority: reset > ext_stall > br_taken > load-use > normal.
  - ext_stall: stall/bubble/flush outputs forced 0; all registers, selects, and counter hold.
  - br_taken with a simultaneous load-use: flush wins, no stall, counter not incremented.
- lu_stall_cnt increments once per load-use stall cycle and saturates at all-ones.
- FSM RUN/LU_STALL is for observability only. RUN->LU_STALL on a load-use; LU_STALL->RUN unconditionally next non-frozen cycle. ext_stall holds the state.

## Timing
- Reset (asynchronous, immediate): all records valid=0, fwd_a_sel=fwd_b_sel=00, lu_stall_cnt=0, state RUN. The combinational outputs then evaluate to 0 unless br_taken.
- Reset mid-stall: stall deasserts immediately; the pending bubble is discarded.
- fwd_*_sel latency: computed in cycle N (consumer in ID), valid throughout cycle N+1 (consumer in EX).
- stall, bubble_id_ex, flush_if_id are same-cycle functions of the inputs and the EX record. There is no register in that path.

## Structure
- Shared package mips_pkg: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; stage-record struct; FSM state enum.
- One natural sub-module: hazard_stage_rec, a single tracking-record register with load/bubble/hold controls, instantiated three times.

## Test plan
- add $3 then sub $5,$3,$4 back-to-back -> consumer in EX: fwd_a_sel=01, fwd_b_sel=00; no stall.
- add $3; nop; or $6,$7,$3 -> fwd_b_sel=10.
- lw $2 then add $4,$2,$2 -> one cycle stall=1, bubble_id_ex=1, lu_stall_cnt 0->1; consumer in EX with fwd_a_sel=fwd_b_sel=10.
- add $0,$1,$1 then add $5,$0,$0 -> selects 00 (r0 never forwarded).
- lw $2 with dependent in ID and br_taken=1 same cycle -> flush_if_id=1, stall=0, counter unchanged.
- ext_stall held 3 cycles during a load-use -> outputs 0, selects and counter frozen. Stall resumes on release. rst_n low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: operand-mux
// select encodings, the stage tracking record and the hazard FSM states.
package mips_pkg;

  // Operand-mux select encodings; 2'b11 has no mux arm and is never driven
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned MIPS_REG_AW = 5;

  // One in-flight instruction as seen by the hazard unit
  typedef struct packed {
    logic                   valid;
    logic [MIPS_REG_AW-1:0] dest;
    logic                   reg_write;
    logic                   mem_read;
  } stage_rec_t;

  // Observability-only hazard state
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } hz_state_t;

  // Nearest producer wins; a WB-stage producer reads back from the register
  // file because the write lands in the first half-cycle
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return FWD_MEM;
    else if (hit_mem) return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// Single pipeline-stage tracking record with hold and bubble controls.
module hazard_stage_rec
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  output logic              rec_valid,
  output logic [REG_AW-1:0] rec_dest,
  output logic              rec_reg_write,
  output logic              rec_mem_read
);

  // Hold while frozen, load an empty record on a bubble, otherwise advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid     <= 1'b0;
      rec_dest      <= '0;
      rec_reg_write <= 1'b0;
      rec_mem_read  <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        rec_valid     <= 1'b0;
        rec_dest      <= '0;
        rec_reg_write <= 1'b0;
        rec_mem_read  <= 1'b0;
      end else begin
        rec_valid     <= in_valid;
        rec_dest      <= in_dest;
        rec_reg_write <= in_reg_write;
        rec_mem_read  <= in_mem_read;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destinations, registers operand-mux selects into EX,
// stalls one cycle on load-use and squashes on a taken branch.
module hazard_fwd_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_stall,
  input  logic              br_taken,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [CNT_W-1:0]  lu_stall_cnt
);

  logic              ex_valid, mem_valid, wb_valid;
  logic [REG_AW-1:0] ex_dest, mem_dest, wb_dest;
  logic              ex_rw, mem_rw, wb_rw;
  logic              ex_mr, mem_mr, wb_mr;

  logic              hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
  logic              load_use;
  hz_state_t         state;

  function automatic logic rec_match(
    input logic              uses,
    input logic [REG_AW-1:0] src,
    input logic              rv,
    input logic              rw,
    input logic [REG_AW-1:0] dest
  );
    return uses && (src != '0) && rv && rw && (dest == src);
  endfunction

  hazard_stage_rec #(.REG_AW(REG_AW)) u_ex_rec (
    .clk(clk), .rst_n(rst_n), .hold(ext_stall), .bubble(bubble_id_ex),
    .in_valid(id_valid), .in_dest(id_dest), .in_reg_write(id_reg_write),
    .in_mem_read(id_mem_read),
    .rec_valid(ex_valid), .rec_dest(ex_dest), .rec_reg_write(ex_rw),
    .rec_mem_read(ex_mr)
  );

  hazard_stage_rec #(.REG_AW(REG_AW)) u_mem_rec (
    .clk(clk), .rst_n(rst_n), .hold(ext_stall), .bubble(1'b0),
    .in_valid(ex_valid), .in_dest(ex_dest), .in_reg_write(ex_rw),
    .in_mem_read(ex_mr),
    .rec_valid(mem_valid), .rec_dest(mem_dest), .rec_reg_write(mem_rw),
    .rec_mem_read(mem_mr)
  );

  hazard_stage_rec #(.REG_AW(REG_AW)) u_wb_rec (
    .clk(clk), .rst_n(rst_n), .hold(ext_stall), .bubble(1'b0),
    .in_valid(mem_valid), .in_dest(mem_dest), .in_reg_write(mem_rw),
    .in_mem_read(mem_mr),
    .rec_valid(wb_valid), .rec_dest(wb_dest), .rec_reg_write(wb_rw),
    .rec_mem_read(wb_mr)
  );

  // WB record is tracked for completeness; a WB hit resolves to the register file
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_dest, wb_rw, wb_mr, mem_mr};

  // Producer matches and same-cycle hazard outputs, ext_stall > br_taken > load-use
  always_comb begin
    hit_ex_rs    = rec_match(id_uses_rs, id_rs, ex_valid, ex_rw, ex_dest);
    hit_ex_rt    = rec_match(id_uses_rt, id_rt, ex_valid, ex_rw, ex_dest);
    hit_mem_rs   = rec_match(id_uses_rs, id_rs, mem_valid, mem_rw, mem_dest);
    hit_mem_rt   = rec_match(id_uses_rt, id_rt, mem_valid, mem_rw, mem_dest);
    load_use     = id_valid && ex_mr && (hit_ex_rs || hit_ex_rt);
    stall        = !ext_stall && !br_taken && load_use;
    bubble_id_ex = !ext_stall && (br_taken || load_use);
    flush_if_id  = !ext_stall && br_taken;
  end

  // Register operand selects into EX; a bubbled slot gets register-file selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (!ext_stall) begin
      if (bubble_id_ex) begin
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end else begin
        fwd_a_sel <= fwd_pick(hit_ex_rs, hit_mem_rs);
        fwd_b_sel <= fwd_pick(hit_ex_rt, hit_mem_rt);
      end
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt <= '0;
    end else if (stall && (lu_stall_cnt != '1)) begin
      lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
    end
  end

  // Observability FSM: one LU_STALL cycle per load-use, held while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (!ext_stall) begin
      case (state)
        ST_RUN:      state <= stall ? ST_LU_STALL : ST_RUN;
        ST_LU_STALL: state <= ST_RUN;
        default:     state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: a table of per-cycle ID-stage
// instructions with hand-derived expectations.
module tb_hazard_fwd_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ext_stall, br_taken, id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_dest;
  logic              id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic              stall, bubble_id_ex, flush_if_id;
  logic [CNT_W-1:0]  lu_stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .br_taken(br_taken),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .lu_stall_cnt(lu_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic br, xs, v;
    logic [4:0] rs, rt;
    logic ur, ut;
    logic [4:0] d;
    logic rw, mr;
    logic es, eb, ef;
    logic [1:0] ea, ebs;
    logic [1:0] ec;
  } step_t;

  typedef struct {
    logic [1:0] a, b, c;
    int         idx;
  } exp_t;

  step_t steps[$];
  exp_t  sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic step_t mk(
    input logic br, input logic xs, input logic v,
    input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
    input logic [4:0] d, input logic rw, input logic mr,
    input logic es, input logic eb, input logic ef,
    input logic [1:0] ea, input logic [1:0] ebs, input logic [1:0] ec
  );
    step_t s;
    s.br = br; s.xs = xs; s.v = v; s.rs = rs; s.rt = rt; s.ur = ur; s.ut = ut;
    s.d = d; s.rw = rw; s.mr = mr; s.es = es; s.eb = eb; s.ef = ef;
    s.ea = ea; s.ebs = ebs; s.ec = ec;
    return s;
  endfunction

  task automatic drive(input step_t s);
    br_taken = s.br; ext_stall = s.xs; id_valid = s.v;
    id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.ur; id_uses_rt = s.ut;
    id_dest = s.d; id_reg_write = s.rw; id_mem_read = s.mr;
  endtask

  initial begin
    exp_t e;
    //           br xs v  rs  rt ur ut d  rw mr  st bu fl  a      b      cnt
    steps.push_back(mk(0,0,1, 1, 2, 1,1, 3, 1,0, 0,0,0, 2'b00, 2'b00, 2'd0)); // 1 add $3,$1,$2
    steps.push_back(mk(0,0,1, 3, 4, 1,1, 5, 1,0, 0,0,0, 2'b01, 2'b00, 2'd0)); // 2 sub $5,$3,$4
    steps.push_back(mk(0,0,1, 1, 1, 1,1, 3, 1,0, 0,0,0, 2'b00, 2'b00, 2'd0)); // 3 add $3,$1,$1
    steps.push_back(mk(0,0,1, 0, 0, 0,0, 0, 0,0, 0,0,0, 2'b00, 2'b00, 2'd0)); // 4 nop
    steps.push_back(mk(0,0,1, 7, 3, 1,1, 6, 1,0, 0,0,0, 2'b00, 2'b10, 2'd0)); // 5 or $6,$7,$3
    steps.push_back(mk(0,0,1, 3, 0, 1,0, 2, 1,1, 0,0,0, 2'b00, 2'b00, 2'd0)); // 6 lw $2,($3) WB hit
    steps.push_back(mk(0,0,1, 2, 2, 1,1, 4, 1,0, 1,1,0, 2'b00, 2'b00, 2'd1)); // 7 add $4,$2,$2 stall
    steps.push_back(mk(0,0,1, 2, 2, 1,1, 4, 1,0, 0,0,0, 2'b10, 2'b10, 2'd1)); // 8 replay
    steps.push_back(mk(0,0,1, 1, 1, 1,1, 0, 1,0, 0,0,0, 2'b00, 2'b00, 2'd1)); // 9 add $0,$1,$1
    steps.push_back(mk(0,0,1, 0, 0, 1,1, 5, 1,0, 0,0,0, 2'b00, 2'b00, 2'd1)); // 10 add $5,$0,$0
    steps.push_back(mk(0,0,1, 1, 0, 1,0, 2, 1,1, 0,0,0, 2'b00, 2'b00, 2'd1)); // 11 lw $2,($1)
    steps.push_back(mk(1,0,1, 2, 3, 1,1, 4, 1,0, 0,1,1, 2'b00, 2'b00, 2'd1)); // 12 dep + branch
    steps.push_back(mk(0,0,1, 2, 2, 1,1, 7, 1,0, 0,0,0, 2'b10, 2'b10, 2'd1)); // 13 add $7,$2,$2
    steps.push_back(mk(0,0,1, 7, 0, 1,0, 2, 1,1, 0,0,0, 2'b01, 2'b00, 2'd1)); // 14 lw $2,($7)
    steps.push_back(mk(0,1,1, 2, 1, 1,1, 4, 1,0, 0,0,0, 2'b01, 2'b00, 2'd1)); // 15 frozen
    steps.push_back(mk(0,1,1, 2, 1, 1,1, 4, 1,0, 0,0,0, 2'b01, 2'b00, 2'd1)); // 16 frozen
    steps.push_back(mk(0,1,1, 2, 1, 1,1, 4, 1,0, 0,0,0, 2'b01, 2'b00, 2'd1)); // 17 frozen
    steps.push_back(mk(0,0,1, 2, 1, 1,1, 4, 1,0, 1,1,0, 2'b00, 2'b00, 2'd2)); // 18 released stall
    steps.push_back(mk(0,0,1, 2, 1, 1,1, 4, 1,0, 0,0,0, 2'b10, 2'b00, 2'd2)); // 19 replay
    steps.push_back(mk(0,0,1, 1, 0, 1,0, 2, 1,1, 0,0,0, 2'b00, 2'b00, 2'd2)); // 20 lw
    steps.push_back(mk(0,0,1, 2, 2, 1,1, 4, 1,0, 1,1,0, 2'b00, 2'b00, 2'd3)); // 21 stall
    steps.push_back(mk(0,0,1, 2, 2, 1,1, 4, 1,0, 0,0,0, 2'b10, 2'b10, 2'd3)); // 22 replay
    steps.push_back(mk(0,0,1, 1, 0, 1,0, 2, 1,1, 0,0,0, 2'b00, 2'b00, 2'd3)); // 23 lw
    steps.push_back(mk(0,0,1, 2, 2, 1,1, 4, 1,0, 1,1,0, 2'b00, 2'b00, 2'd3)); // 24 stall, saturated
    steps.push_back(mk(0,0,1, 2, 2, 1,1, 4, 1,0, 0,0,0, 2'b10, 2'b10, 2'd3)); // 25 replay
    steps.push_back(mk(0,0,1, 1, 0, 1,0, 2, 1,1, 0,0,0, 2'b00, 2'b00, 2'd3)); // 26 lw

    rst_n = 1'b0;
    drive(mk(0,0,0, 0,0, 0,0, 0, 0,0, 0,0,0, 2'b00, 2'b00, 2'd0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_val("rst_a_sel", fwd_a_sel, 2'b00);
    check_val("rst_b_sel", fwd_b_sel, 2'b00);
    check_val("rst_cnt",   lu_stall_cnt, 2'd0);
    check_val("rst_stall", stall, 1'b0);
    check_val("rst_bubble", bubble_id_ex, 1'b0);
    check_val("rst_flush", flush_if_id, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < steps.size(); i++) begin
      drive(steps[i]);
      #2;
      check_val($sformatf("s%0d_stall", i + 1), stall, steps[i].es);
      check_val($sformatf("s%0d_bubble", i + 1), bubble_id_ex, steps[i].eb);
      check_val($sformatf("s%0d_flush", i + 1), flush_if_id, steps[i].ef);
      e.a = steps[i].ea; e.b = steps[i].ebs; e.c = steps[i].ec; e.idx = i + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check_val($sformatf("s%0d_sb_empty", i + 1), 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check_val($sformatf("s%0d_a_sel", e.idx), fwd_a_sel, e.a);
        check_val($sformatf("s%0d_b_sel", e.idx), fwd_b_sel, e.b);
        check_val($sformatf("s%0d_cnt", e.idx), lu_stall_cnt, e.c);
      end
    end

    // Load-use in progress, then asynchronous reset mid-stall
    drive(mk(0,0,1, 2,2, 1,1, 4, 1,0, 0,0,0, 2'b00, 2'b00, 2'd0));
    #2;
    check_val("pre_rst_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_stall", stall, 1'b0);
    check_val("midrst_bubble", bubble_id_ex, 1'b0);
    check_val("midrst_flush", flush_if_id, 1'b0);
    check_val("midrst_a_sel", fwd_a_sel, 2'b00);
    check_val("midrst_b_sel", fwd_b_sel, 2'b00);
    check_val("midrst_cnt", lu_stall_cnt, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
